// File: rtl/rx_controller_pkg.sv
// Shared types for the UART receive controller and its datapath.
//   controlPoints_t : enables and clears driven into the clk/sample/bit
//                     counters and the SIPO shift register.
//   rx_state_t      : receive sequencer states.
package rx_controller_pkg;

    typedef struct packed {
        logic clk_en;
        logic clk_clr;
        logic sample_en;
        logic sample_clr;
        logic bit_en;
        logic bit_clr;
        logic data_en;
        logic data_clr;
    } controlPoints_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int SYNC_DEPTH = 2;

    // Parked datapath: every enable low, every clear high.
    function automatic controlPoints_t cpts_parked();
        controlPoints_t cp;
        cp            = '0;
        cp.clk_clr    = 1'b1;
        cp.sample_clr = 1'b1;
        cp.bit_clr    = 1'b1;
        cp.data_clr   = 1'b1;
        return cp;
    endfunction

endpackage

// File: rtl/rx_controller_if.sv
// Consumer-side handshake of the receive controller.
//   master : rx_controller (drives data, valid and error flags; takes ready)
//   slave  : byte consumer
interface rx_controller_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  framing_err;
    logic                  overrun_err;

    modport master (
        output rx_data, rx_valid, framing_err, overrun_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, framing_err, overrun_err,
        output rx_ready
    );
endinterface

// File: rtl/rx_controller_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
//   clock, reset_n : system clock, async active-low reset
//   i_d            : asynchronous input
//   o_q            : synchronised output, lags i_d by DEPTH cycles
// Flops reset to RESET_VAL so an idle-high line looks idle out of reset.
module rx_controller_sync #(
    parameter int   DEPTH     = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_d,
    output logic o_q
);
    logic [DEPTH-1:0] r_chain;

    // Shift chain of synchroniser flops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_chain <= {DEPTH{RESET_VAL}};
        end else begin
            r_chain <= {r_chain[DEPTH-2:0], i_d};
        end
    end

    assign o_q = r_chain[DEPTH-1];
endmodule

// File: rtl/rx_controller.sv
// UART receive sequencer.
//   clock, reset_n        : system clock, async active-low reset
//   rx_in                 : raw serial line (idle high)
//   sample, midbit        : datapath sample tick and mid-bit flag
//   sample_count          : datapath sample counter
//   bit_count, shift_data : datapath bit counter and SIPO contents
//   rx_sync               : synchronised line, feeds the datapath data_in
//   cPts                  : datapath enables/clears
//   busy                  : registered, high whenever the FSM is not IDLE
//   rx_if (master)        : rx_data/rx_valid/rx_ready, framing_err, overrun_err
module rx_controller
    import rx_controller_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    localparam int SC_W      = $clog2(OVERSAMPLE),
    localparam int BC_W      = $clog2(DATA_WIDTH)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  rx_in,
    input  logic                  sample,
    input  logic                  midbit,
    input  logic [SC_W-1:0]       sample_count,
    input  logic [BC_W-1:0]       bit_count,
    input  logic [DATA_WIDTH-1:0] shift_data,
    output logic                  rx_sync,
    output controlPoints_t        cPts,
    output logic                  busy,
    rx_controller_if.master       rx_if
);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_WIDTH - 1);

    rx_state_t             r_state;
    rx_state_t             w_next_state;
    controlPoints_t        w_cpts;
    logic                  w_sync;
    logic                  w_half_tick;
    logic                  w_full_tick;
    logic                  w_complete;
    logic                  w_handshake;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic                  r_rx_valid;
    logic                  r_framing_err;
    logic                  r_overrun_err;
    logic                  r_busy;

    rx_controller_sync #(
        .DEPTH     (SYNC_DEPTH),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .i_d     (rx_in),
        .o_q     (w_sync)
    );

    assign w_half_tick = sample & midbit;
    assign w_full_tick = sample & (sample_count == SC_LAST);
    assign w_complete  = (r_state == STOP) & w_full_tick;
    assign w_handshake = r_rx_valid & rx_if.rx_ready;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (!w_sync) w_next_state = START;
                else         w_next_state = IDLE;
            end
            START: begin
                // A line that is high again at mid-start-bit was only a glitch.
                if (w_half_tick) w_next_state = w_sync ? IDLE : DATA;
                else             w_next_state = START;
            end
            DATA: begin
                if (w_full_tick && (bit_count == BC_LAST)) w_next_state = STOP;
                else                                       w_next_state = DATA;
            end
            STOP: begin
                if (w_full_tick) w_next_state = IDLE;
                else             w_next_state = STOP;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath control points decoded from state and ticks.
    always_comb begin
        w_cpts = '0;
        case (r_state)
            IDLE: w_cpts = cpts_parked();
            START: begin
                w_cpts.clk_en     = 1'b1;
                w_cpts.sample_en  = sample;
                // Restart the sample count at mid-start-bit so that every
                // later full_tick falls on a bit centre.
                w_cpts.sample_clr = w_half_tick & ~w_sync;
            end
            DATA: begin
                w_cpts.clk_en    = 1'b1;
                w_cpts.sample_en = sample;
                w_cpts.data_en   = w_full_tick;
                w_cpts.bit_en    = w_full_tick;
            end
            STOP: begin
                w_cpts.clk_en    = 1'b1;
                w_cpts.sample_en = sample;
            end
            default: w_cpts = cpts_parked();
        endcase
    end

    // Received byte, handshake and error flags; a completion outranks a
    // same-cycle handshake so a new byte is never dropped.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_framing_err <= 1'b0;
            r_overrun_err <= 1'b0;
        end else if (w_complete) begin
            r_rx_data     <= shift_data;
            r_rx_valid    <= 1'b1;
            r_framing_err <= ~w_sync;
            r_overrun_err <= r_rx_valid & ~rx_if.rx_ready;
        end else if (w_handshake) begin
            r_rx_valid    <= 1'b0;
            r_framing_err <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_rx_valid    <= r_rx_valid;
            r_framing_err <= r_framing_err;
            r_overrun_err <= r_overrun_err;
        end
    end

    // Busy flag, registered from the next state so it tracks the state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= (w_next_state != IDLE);
        end
    end

    assign rx_sync           = w_sync;
    assign cPts              = w_cpts;
    assign busy              = r_busy;
    assign rx_if.rx_data     = r_rx_data;
    assign rx_if.rx_valid    = r_rx_valid;
    assign rx_if.framing_err = r_framing_err;
    assign rx_if.overrun_err = r_overrun_err;
endmodule

// File: tb/tb_rx_controller.sv
module tb_rx_controller;
    import rx_controller_pkg::*;

    localparam int BIT_CLKS = 32;   // 2 clocks per sample x 16 samples per bit

    logic           clock = 1'b0;
    logic           reset_n;
    logic           rx_in;
    logic           sample;
    logic           midbit;
    logic [3:0]     sample_count;
    logic [2:0]     bit_count;
    logic [7:0]     shift_data;
    logic           rx_sync;
    controlPoints_t cPts;
    logic           busy;

    rx_controller_if #(.DATA_WIDTH(8)) rx_if ();

    rx_controller #(.DATA_WIDTH(8), .OVERSAMPLE(16)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .rx_in        (rx_in),
        .sample       (sample),
        .midbit       (midbit),
        .sample_count (sample_count),
        .bit_count    (bit_count),
        .shift_data   (shift_data),
        .rx_sync      (rx_sync),
        .cPts         (cPts),
        .busy         (busy),
        .rx_if        (rx_if)
    );

    always #5 clock = ~clock;

    // ---------------- datapath model (clock divider, counters, SIPO) -------
    logic [1:0] div_cnt;
    logic [3:0] tick_cnt;   // full ticks since the bit counter was last cleared
    logic       full_tick;

    assign sample    = cPts.clk_en & (div_cnt == 2'd1);
    assign midbit    = (sample_count == 4'd7);
    assign full_tick = sample & (sample_count == 4'd15);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt      <= 2'd0;
            sample_count <= 4'd0;
            bit_count    <= 3'd0;
            shift_data   <= 8'd0;
            tick_cnt     <= 4'd0;
        end else begin
            if (cPts.clk_clr)         div_cnt <= 2'd0;
            else if (cPts.clk_en)     div_cnt <= (div_cnt == 2'd1) ? 2'd0 : div_cnt + 2'd1;
            if (cPts.sample_clr)      sample_count <= 4'd0;
            else if (cPts.sample_en)  sample_count <= sample_count + 4'd1;
            if (cPts.bit_clr)         bit_count <= 3'd0;
            else if (cPts.bit_en)     bit_count <= bit_count + 3'd1;
            if (cPts.data_clr)        shift_data <= 8'd0;
            else if (cPts.data_en)    shift_data <= {rx_sync, shift_data[7:1]};
            if (cPts.bit_clr)         tick_cnt <= 4'd0;
            else if (full_tick)       tick_cnt <= tick_cnt + 4'd1;
        end
    end

    // ---------------- checking helpers --------------------------------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Compare the handshake outputs at the next falling edge.
    task automatic check_out(input string tag, input logic [7:0] data, input logic fe,
                             input logic ov, input logic valid);
        @(negedge clock);
        check({tag, ".valid"}, 32'(rx_if.rx_valid), 32'(valid));
        if (valid) begin
            check({tag, ".data"}, 32'(rx_if.rx_data), 32'(data));
            check({tag, ".framing"}, 32'(rx_if.framing_err), 32'(fe));
        end
        check({tag, ".overrun"}, 32'(rx_if.overrun_err), 32'(ov));
    endtask

    task automatic hold_line(input logic b);
        rx_in = b;
        repeat (BIT_CLKS) @(posedge clock);
        #1;
    endtask

    // One full frame (start, 8 data bits LSB first, stop), then an idle gap.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        hold_line(1'b0);
        for (int i = 0; i < 8; i++) hold_line(d[i]);
        hold_line(stop);
        rx_in = 1'b1;
        repeat (40) @(posedge clock);
        #1;
    endtask

    // Wait (bounded) for the falling edge just before the stop-bit centre tick.
    task automatic await_completion(output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 600) begin
            @(negedge clock);
            if (full_tick && tick_cnt == 4'd8) ok = 1'b1;
            n++;
        end
    endtask

    // One-cycle rx_ready pulse; rx_valid must be low on the following cycle.
    task automatic accept(input string tag);
        rx_if.rx_ready = 1'b1;
        @(posedge clock);
        #1;
        rx_if.rx_ready = 1'b0;
        check_out(tag, 8'd0, 1'b0, 1'b0, 1'b0);
        check({tag, ".framing_clr"}, 32'(rx_if.framing_err), 32'd0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_fe;
    } vec_t;

    vec_t vecs[4];
    bit   ok;
    bit   pending;
    logic [7:0] rd;
    logic       rs;
    bit   racc;

    initial begin
        vecs[0] = '{data: 8'h00, stop: 1'b1, exp_data: 8'h00, exp_fe: 1'b0};
        vecs[1] = '{data: 8'hFF, stop: 1'b1, exp_data: 8'hFF, exp_fe: 1'b0};
        vecs[2] = '{data: 8'h81, stop: 1'b0, exp_data: 8'h81, exp_fe: 1'b1};
        vecs[3] = '{data: 8'h6E, stop: 1'b1, exp_data: 8'h6E, exp_fe: 1'b0};

        reset_n        = 1'b0;
        rx_in          = 1'b1;
        rx_if.rx_ready = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst.valid", 32'(rx_if.rx_valid), 32'd0);
        check("rst.data", 32'(rx_if.rx_data), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.cpts", 32'(cPts), 32'h55);
        check("rst.sync", 32'(rx_sync), 32'd1);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (4) @(posedge clock);
        #1;

        // 0xA5: valid rises one cycle after the stop tick, then holds until ready.
        fork
            send_frame(8'hA5, 1'b1);
            begin
                await_completion(ok);
                check("a5.done_seen", 32'(ok), 32'd1);
                check("a5.valid_pre", 32'(rx_if.rx_valid), 32'd0);
                @(negedge clock);
                check("a5.valid_rise", 32'(rx_if.rx_valid), 32'd1);
            end
        join
        check_out("a5", 8'hA5, 1'b0, 1'b0, 1'b1);
        repeat (50) @(posedge clock);
        #1;
        check_out("a5.hold", 8'hA5, 1'b0, 1'b0, 1'b1);
        accept("a5.acc");

        // 10-clock low glitch: START entered, abandoned at the half tick.
        rx_in = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        check("glitch.busy_hi", 32'(busy), 32'd1);
        repeat (4) @(posedge clock);
        #1;
        rx_in = 1'b1;
        repeat (40) @(posedge clock);
        #1;
        check("glitch.busy_lo", 32'(busy), 32'd0);
        check_out("glitch", 8'd0, 1'b0, 1'b0, 1'b0);

        // 0x3C with a low stop bit.
        send_frame(8'h3C, 1'b0);
        check_out("3c", 8'h3C, 1'b1, 1'b0, 1'b1);
        accept("3c.acc");

        // Two frames with no ready: second overwrites, overrun set.
        send_frame(8'h11, 1'b1);
        check_out("b2b.first", 8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 1'b1);
        check_out("b2b.second", 8'h22, 1'b0, 1'b1, 1'b1);
        accept("b2b.acc");

        // Completion in the same cycle as a handshake on the pending byte.
        send_frame(8'h77, 1'b1);
        check_out("coin.first", 8'h77, 1'b0, 1'b0, 1'b1);
        fork
            send_frame(8'h99, 1'b1);
            begin
                await_completion(ok);
                check("coin.done_seen", 32'(ok), 32'd1);
                check("coin.pend", 32'(rx_if.rx_valid), 32'd1);
                rx_if.rx_ready = 1'b1;
                @(posedge clock);
                #1;
                rx_if.rx_ready = 1'b0;
            end
        join
        check_out("coin", 8'h99, 1'b0, 1'b0, 1'b1);

        // Reset during bit 4 of 0xFF drops the frame and the pending 0x99.
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (BIT_CLKS * 5 + 16) @(posedge clock);
                #1;
                check("mid.busy", 32'(busy), 32'd1);
                reset_n = 1'b0;
                #2;
                check("mid.valid", 32'(rx_if.rx_valid), 32'd0);
                check("mid.data", 32'(rx_if.rx_data), 32'd0);
                check("mid.busy_rst", 32'(busy), 32'd0);
                check("mid.cpts", 32'(cPts), 32'h55);
                check("mid.sync", 32'(rx_sync), 32'd1);
                repeat (3) @(posedge clock);
                #1;
                reset_n = 1'b1;
            end
        join
        check_out("mid.after", 8'd0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b1);
        check_out("5a", 8'h5A, 1'b0, 1'b0, 1'b1);
        accept("5a.acc");

        // Vector table.
        for (int v = 0; v < 4; v++) begin
            send_frame(vecs[v].data, vecs[v].stop);
            check_out($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_fe, 1'b0, 1'b1);
            accept($sformatf("vec%0d.acc", v));
        end

        // Random frames against a pending-byte reference model.
        pending = 1'b0;
        for (int r = 0; r < 8; r++) begin
            rd   = 8'($urandom_range(0, 255));
            rs   = 1'($urandom_range(0, 1));
            racc = 1'($urandom_range(0, 1));
            send_frame(rd, rs);
            check_out($sformatf("rnd%0d", r), rd, ~rs, pending, 1'b1);
            pending = 1'b1;
            if (racc) begin
                accept($sformatf("rnd%0d.acc", r));
                pending = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
